// File: rtl/camerametnios_camera_output.sv
// Avalon-MM output port for the camera subsystem: a static control word plus a
// valid/ready command channel with timeout, completion counter and sticky status.
module camerametnios_camera_output #(
  parameter int unsigned           DATA_WIDTH     = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter int unsigned           CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready
);

  localparam int unsigned WaitWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WaitWidth-1:0] WaitLast =
      (TIMEOUT_CYCLES > 0) ? WaitWidth'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrSet    = 2'd1;
  localparam logic [1:0] AddrClear  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] cmd_data_q;
  logic [WaitWidth-1:0]  wait_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  overrun_q;
  logic                  timeout_q;
  logic [31:0]           readdata_q;

  logic                  wr;
  logic                  wr_cmd;
  logic                  wr_status_clr;
  logic                  busy;
  logic [DATA_WIDTH-1:0] wd;
  logic [31:0]           status;
  logic                  unused_wd;

  assign wr            = chipselect & ~write_n;
  assign wd            = writedata[DATA_WIDTH-1:0];
  assign wr_cmd        = wr && (address == AddrStatus) && !writedata[31];
  assign wr_status_clr = wr && (address == AddrStatus) && writedata[31];
  assign busy          = (state_q == StBusy);
  assign unused_wd     = ^writedata[31:DATA_WIDTH];

  // Control word register: direct write, bit-set and bit-clear views.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        AddrData:  out_q <= wd;
        AddrSet:   out_q <= out_q | wd;
        AddrClear: out_q <= out_q & ~wd;
        default:   out_q <= out_q;
      endcase
    end
  end

  // Command handshake FSM with timeout, completion counter and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cmd_data_q <= '0;
      wait_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (wr_cmd) begin
            cmd_data_q <= wd;
            wait_q     <= '0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (wr_cmd) begin
            overrun_q <= 1'b1;
          end
          // Completion takes priority over a timeout landing on the same edge.
          if (cmd_ready) begin
            state_q <= StIdle;
            count_q <= count_q + CNT_WIDTH'(1);
          end else if ((TIMEOUT_CYCLES != 0) && (wait_q == WaitLast)) begin
            state_q   <= StIdle;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WaitWidth'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
      // A clear write overrides any flag or counter update on the same edge.
      if (wr_status_clr) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
        count_q   <= '0;
      end
    end
  end

  always_comb begin
    status                    = '0;
    status[0]                 = busy;
    status[1]                 = overrun_q;
    status[2]                 = timeout_q;
    status[16 +: CNT_WIDTH]   = count_q;
  end

  // Read data is registered from the current address every cycle; no read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      case (address)
        AddrData:   readdata_q <= 32'(out_q);
        AddrStatus: readdata_q <= status;
        default:    readdata_q <= '0;
      endcase
    end
  end

  assign readdata  = readdata_q;
  assign out_port  = out_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_valid = busy;

endmodule

// File: tb/tb_camerametnios_camera_output.sv
// Randomized bench for camerametnios_camera_output against a cycle-level behavioural model.
module tb_camerametnios_camera_output;

  localparam int unsigned DW = 12;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;
  localparam int          DMASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic [DW-1:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;

  camerametnios_camera_output #(
    .DATA_WIDTH     (DW),
    .RESET_VALUE    ('0),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: age counts cycles the pending command has been visible.
  int m_out, m_cmd, m_age, m_cnt, m_rd;
  bit m_busy, m_ovr, m_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_out;
      2'd3:    return (m_cnt << 16) | (int'(m_tmo) << 2) | (int'(m_ovr) << 1) | int'(m_busy);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 0; m_cmd = 0; m_age = 0; m_cnt = 0; m_rd = 0;
    m_busy = 0; m_ovr = 0; m_tmo = 0;
  endtask

  task automatic step();
    bit wr;
    @(posedge clk);
    wr = chipselect && !write_n;
    m_rd = model_read(address);
    if (wr && address == 2'd0) m_out = int'(writedata) & DMASK;
    if (wr && address == 2'd1) m_out = m_out | (int'(writedata) & DMASK);
    if (wr && address == 2'd2) m_out = m_out & ~(int'(writedata) & DMASK);
    if (!m_busy) begin
      if (wr && address == 2'd3 && !writedata[31]) begin
        m_busy = 1; m_cmd = int'(writedata) & DMASK; m_age = 1;
      end
    end else begin
      if (wr && address == 2'd3 && !writedata[31]) m_ovr = 1;
      if (cmd_ready) begin
        m_busy = 0; m_cnt = (m_cnt + 1) % (1 << CW);
      end else if (TO != 0 && m_age == TO) begin
        m_busy = 0; m_tmo = 1;
      end else begin
        m_age++;
      end
    end
    if (wr && address == 2'd3 && writedata[31]) begin
      m_ovr = 0; m_tmo = 0; m_cnt = 0;
    end
    #1;
    check("out_port", 32'(out_port), m_out);
    check("cmd_valid", 32'(cmd_valid), 32'(m_busy));
    check("cmd_data", 32'(cmd_data), m_cmd);
    check("readdata", readdata, m_rd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Static control word: direct, set, clear.
    wr_reg(2'd0, 32'h0000_0ABC);
    check("data_wr", 32'(out_port), 32'hABC);
    address = 2'd0; step();
    check("data_rd", readdata, 32'h0000_0ABC);
    wr_reg(2'd0, 32'h0F0);
    wr_reg(2'd1, 32'h00F);
    check("set_wr", 32'(out_port), 32'h0FF);
    wr_reg(2'd2, 32'h0F0);
    check("clr_wr", 32'(out_port), 32'h00F);
    address = 2'd1; step();
    check("set_rd", readdata, 32'h0);
    address = 2'd2; step();
    check("clr_rd", readdata, 32'h0);

    // Command held for five cycles, then accepted on the sixth.
    wr_reg(2'd3, 32'h123);
    idle(4);
    check("cmd_held", 32'(cmd_valid), 32'h1);
    check("cmd_word", 32'(cmd_data), 32'h123);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    check("cmd_done", 32'(cmd_valid), 32'h0);
    address = 2'd3; step();
    check("status_cnt1", readdata, 32'h0001_0000);

    // Overrun while busy, then clear.
    wr_reg(2'd3, 32'h123);
    wr_reg(2'd3, 32'h456);
    check("ovr_keep", 32'(cmd_data), 32'h123);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    step();
    check("ovr_status", readdata, 32'h0002_0002);
    wr_reg(2'd3, 32'h8000_0000);
    step();
    check("status_clr", readdata, 32'h0);

    // Timeout after exactly TO cycles.
    wr_reg(2'd3, 32'h055);
    idle(TO - 1);
    check("to_busy", 32'(cmd_valid), 32'h1);
    step();
    check("to_drop", 32'(cmd_valid), 32'h0);
    step();
    check("to_status", readdata, 32'h4);
    wr_reg(2'd3, 32'h8000_0000);
    // Ready on the last allowed cycle completes instead of timing out.
    wr_reg(2'd3, 32'h066);
    idle(TO - 1);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    step();
    check("to_edge_done", readdata, 32'h0001_0000);

    // Clear coinciding with completion; command write coinciding with completion.
    wr_reg(2'd3, 32'h011);
    cmd_ready = 1'b1; wr_reg(2'd3, 32'h8000_0000); cmd_ready = 1'b0;
    step();
    check("clr_vs_done", readdata, 32'h0);
    wr_reg(2'd3, 32'h022);
    cmd_ready = 1'b1; wr_reg(2'd3, 32'h321); cmd_ready = 1'b0;
    step();
    check("wr_vs_done", readdata, 32'h0001_0002);

    // Asynchronous reset in the middle of a transfer.
    wr_reg(2'd0, 32'h5A5);
    wr_reg(2'd3, 32'h777);
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(cmd_valid), 32'h0);
    check("arst_readdata", readdata, 32'h0);
    check("arst_out_port", 32'(out_port), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("arst_count", readdata, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom();
      writedata[31] = ($urandom_range(0, 7) == 0);
      cmd_ready  = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
